// File: rtl/j1_pkg.sv
// Shared constants, instruction classes, ALU opcodes and stack-delta decode
// for the J1a 16-bit stack CPU.
package j1_pkg;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int PCW   = 13;
  localparam int SPW   = $clog2(DEPTH);

  typedef enum logic [2:0] {
    CLS_JMP  = 3'd0,
    CLS_JZ   = 3'd1,
    CLS_CALL = 3'd2,
    CLS_ALU  = 3'd3,
    CLS_LIT  = 3'd4
  } insn_cls_e;

  typedef enum logic [3:0] {
    OP_T     = 4'd0,
    OP_N     = 4'd1,
    OP_ADD   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_INV   = 4'd6,
    OP_EQ    = 4'd7,
    OP_LT    = 4'd8,
    OP_SRA   = 4'd9,
    OP_SHL   = 4'd10,
    OP_R     = 4'd11,
    OP_SUB   = 4'd12,
    OP_LD    = 4'd13,
    OP_DEPTH = 4'd14,
    OP_ULT   = 4'd15
  } alu_op_e;

  // Top three instruction bits select the class; bit 15 alone marks a literal.
  function automatic insn_cls_e insn_class(input logic [2:0] top);
    insn_cls_e c;
    if (top[2]) begin
      c = CLS_LIT;
    end else begin
      c = insn_cls_e'({1'b0, top[1:0]});
    end
    return c;
  endfunction

  // 2-bit signed delta sign-extended to pointer width (10 means -2).
  function automatic logic [SPW-1:0] stack_delta(input logic [1:0] d);
    return {{(SPW-2){d[1]}}, d};
  endfunction

endpackage

// File: rtl/j1_stack.sv
// Register-file stack: the pointer moves by delta each clock and an optional
// write lands at the new pointer; rd is the entry under the current pointer.
module j1_stack
  import j1_pkg::*;
#(
  parameter int WIDTH = j1_pkg::WIDTH,
  parameter int DEPTH = j1_pkg::DEPTH,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [PW-1:0]    delta,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd,
  output logic [PW-1:0]    sp
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    sp_r;
  logic [PW-1:0]    sp_n_s;

  assign sp_n_s = sp_r + delta;
  assign rd     = mem_r[sp_r];
  assign sp     = sp_r;

  // Pointer update and write at the post-move slot; entries cleared on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_r <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      sp_r <= sp_n_s;
      if (we) begin
        mem_r[sp_n_s] <= wd;
      end
    end
  end

endmodule

// File: rtl/j1.sv
// J1a core: one instruction per clock, T held in st0, N and R taken from the
// data and return stacks; code and data share an external dual-port RAM.
module j1
  import j1_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] insn,
  output logic [PCW-1:0]   code_addr,
  input  logic [WIDTH-1:0] din,
  output logic [PCW-1:0]   mem_addr,
  output logic             mem_wr,
  output logic [WIDTH-1:0] dout
);

  logic [PCW-1:0]   pc_r, pc_n_s, pc_inc_s;
  logic [WIDTH-1:0] st0_r, st0_n_s, st1_s, rst0_s, alu_s, rwd_s;
  logic             reboot_r;
  logic             dwe_s, rwe_s, wr_s;
  logic [1:0]       dd_s, rdl_s;
  logic [SPW-1:0]   dsp_s, rsp_s, dstep_s, rstep_s;

  assign pc_inc_s = pc_r + PCW'(1);
  assign dstep_s  = stack_delta(dd_s);
  assign rstep_s  = stack_delta(rdl_s);

  j1_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dstack (
    .clk   (clk),
    .reset (reset),
    .we    (dwe_s),
    .delta (dstep_s),
    .wd    (st0_r),
    .rd    (st1_s),
    .sp    (dsp_s)
  );

  j1_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rstack (
    .clk   (clk),
    .reset (reset),
    .we    (rwe_s),
    .delta (rstep_s),
    .wd    (rwd_s),
    .rd    (rst0_s),
    .sp    (rsp_s)
  );

  // ALU result for an ALU-class instruction.
  always_comb begin
    alu_s = st0_r;
    case (alu_op_e'(insn[11:8]))
      OP_T:     alu_s = st0_r;
      OP_N:     alu_s = st1_s;
      OP_ADD:   alu_s = st0_r + st1_s;
      OP_AND:   alu_s = st0_r & st1_s;
      OP_OR:    alu_s = st0_r | st1_s;
      OP_XOR:   alu_s = st0_r ^ st1_s;
      OP_INV:   alu_s = ~st0_r;
      OP_EQ:    alu_s = {WIDTH{st1_s == st0_r}};
      OP_LT:    alu_s = {WIDTH{$signed(st1_s) < $signed(st0_r)}};
      OP_SRA:   alu_s = {st0_r[WIDTH-1], st0_r[WIDTH-1:1]};
      OP_SHL:   alu_s = {st0_r[WIDTH-2:0], 1'b0};
      OP_R:     alu_s = rst0_s;
      OP_SUB:   alu_s = st1_s - st0_r;
      OP_LD:    alu_s = din;
      OP_DEPTH: alu_s = {{(WIDTH-2*SPW){1'b0}}, dsp_s, rsp_s};
      OP_ULT:   alu_s = {WIDTH{st1_s < st0_r}};
      default:  alu_s = st0_r;
    endcase
  end

  // Decode and next-state selection; the reboot cycle behaves as a NOP.
  always_comb begin
    st0_n_s = st0_r;
    pc_n_s  = pc_inc_s;
    dwe_s   = 1'b0;
    rwe_s   = 1'b0;
    dd_s    = 2'b00;
    rdl_s   = 2'b00;
    rwd_s   = st0_r;
    wr_s    = 1'b0;
    if (reboot_r) begin
      pc_n_s = pc_r;
    end else begin
      case (insn_class(insn[15:13]))
        CLS_LIT: begin
          st0_n_s = {1'b0, insn[14:0]};
          dwe_s   = 1'b1;
          dd_s    = 2'b01;
        end
        CLS_JMP: pc_n_s = insn[PCW-1:0];
        CLS_JZ: begin
          st0_n_s = st1_s;
          dd_s    = 2'b11;
          pc_n_s  = (st0_r == {WIDTH{1'b0}}) ? insn[PCW-1:0] : pc_inc_s;
        end
        CLS_CALL: begin
          rwe_s  = 1'b1;
          rdl_s  = 2'b01;
          rwd_s  = {{(WIDTH-PCW-1){1'b0}}, pc_inc_s, 1'b0};
          pc_n_s = insn[PCW-1:0];
        end
        CLS_ALU: begin
          // Return address comes from the old R even if T->R overwrites it.
          st0_n_s = alu_s;
          pc_n_s  = insn[12] ? rst0_s[PCW:1] : pc_inc_s;
          dwe_s   = insn[7];
          rwe_s   = insn[6];
          wr_s    = insn[5];
          rdl_s   = insn[3:2];
          dd_s    = insn[1:0];
        end
        default: pc_n_s = pc_inc_s;
      endcase
    end
  end

  // Core state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r     <= {PCW{1'b0}};
      st0_r    <= {WIDTH{1'b0}};
      reboot_r <= 1'b1;
    end else begin
      pc_r     <= pc_n_s;
      st0_r    <= st0_n_s;
      reboot_r <= 1'b0;
    end
  end

  assign code_addr = pc_n_s;
  assign mem_addr  = st0_n_s[PCW-1:0];
  assign mem_wr    = wr_s;
  assign dout      = st1_s;

endmodule

// File: tb/tb_j1.sv
// Bench for j1: a hand-derived directed vector table followed by random
// instructions checked against an array-based reference model.
module tb_j1;

  logic        clk;
  logic        reset;
  logic [15:0] insn;
  logic [12:0] code_addr;
  logic [15:0] din;
  logic [12:0] mem_addr;
  logic        mem_wr;
  logic [15:0] dout;

  int n_cmp = 0;
  int n_err = 0;

  j1 dut (
    .clk       (clk),
    .reset     (reset),
    .insn      (insn),
    .code_addr (code_addr),
    .din       (din),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .dout      (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data side of the external RAM: read-before-write, one-cycle read latency.
  logic [15:0] ram [8192];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= dout;
    din <= ram[mem_addr];
  end

  // Reference model state.
  logic [15:0] m_ds [16];
  logic [15:0] m_rs [16];
  logic [15:0] m_ram [8192];
  logic [15:0] m_T, m_din;
  int          m_pc, m_dsp, m_rsp;
  bit          m_reboot;

  typedef struct {
    logic [15:0] insn;
    logic [12:0] code;
    logic [12:0] maddr;
    logic        wr;
    logic [15:0] dout;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sgn2(input logic [1:0] d);
    return d[1] ? int'(d) - 4 : int'(d);
  endfunction

  function automatic logic [15:0] model_alu(input logic [3:0] op, input logic [15:0] t,
                                            input logic [15:0] n, input logic [15:0] r);
    logic [15:0] v;
    case (op)
      4'd0:  v = t;
      4'd1:  v = n;
      4'd2:  v = t + n;
      4'd3:  v = t & n;
      4'd4:  v = t | n;
      4'd5:  v = t ^ n;
      4'd6:  v = ~t;
      4'd7:  v = (n == t) ? 16'hFFFF : 16'h0000;
      4'd8:  v = ($signed(n) < $signed(t)) ? 16'hFFFF : 16'h0000;
      4'd9:  v = 16'($signed(t) >>> 1);
      4'd10: v = 16'(t * 2);
      4'd11: v = r;
      4'd12: v = n - t;
      4'd13: v = m_din;
      4'd14: v = 16'(m_dsp * 16 + m_rsp);
      default: v = (n < t) ? 16'hFFFF : 16'h0000;
    endcase
    return v;
  endfunction

  task automatic model_step(input logic [15:0] i, output logic [12:0] e_code,
                            output logic [12:0] e_maddr, output logic e_wr,
                            output logic [15:0] e_dout);
    logic [15:0] n, r, t_next, rdv;
    int pc1, pc_next;
    n = m_ds[m_dsp];
    r = m_rs[m_rsp];
    pc1 = (m_pc + 1) % 8192;
    t_next = m_T;
    pc_next = pc1;
    e_wr = 1'b0;
    if (m_reboot) begin
      pc_next = m_pc;
      m_reboot = 1'b0;
    end else if (i[15]) begin
      m_dsp = (m_dsp + 1) % 16;
      m_ds[m_dsp] = m_T;
      t_next = {1'b0, i[14:0]};
    end else if (i[14:13] == 2'b00) begin
      pc_next = int'(i[12:0]);
    end else if (i[14:13] == 2'b01) begin
      if (m_T == 16'h0000) pc_next = int'(i[12:0]);
      t_next = n;
      m_dsp = (m_dsp + 15) % 16;
    end else if (i[14:13] == 2'b10) begin
      m_rsp = (m_rsp + 1) % 16;
      m_rs[m_rsp] = 16'(pc1 * 2);
      pc_next = int'(i[12:0]);
    end else begin
      t_next = model_alu(i[11:8], m_T, n, r);
      if (i[12]) pc_next = int'(r[13:1]);
      m_dsp = (m_dsp + sgn2(i[1:0]) + 16) % 16;
      m_rsp = (m_rsp + sgn2(i[3:2]) + 16) % 16;
      if (i[7]) m_ds[m_dsp] = m_T;
      if (i[6]) m_rs[m_rsp] = m_T;
      e_wr = i[5];
    end
    e_code  = 13'(pc_next);
    e_maddr = t_next[12:0];
    e_dout  = n;
    rdv = m_ram[e_maddr];
    if (e_wr) m_ram[e_maddr] = n;
    m_din = rdv;
    m_T   = t_next;
    m_pc  = pc_next;
  endtask

  task automatic addv(input logic [15:0] i, input logic [12:0] c, input logic [12:0] a,
                      input logic w, input logic [15:0] d);
    vec_t v;
    v.insn = i; v.code = c; v.maddr = a; v.wr = w; v.dout = d;
    vecs.push_back(v);
  endtask

  initial begin
    logic [12:0] e_code, e_maddr;
    logic        e_wr;
    logic [15:0] e_dout, ri;

    for (int k = 0; k < 8192; k++) begin
      ram[k] = 16'h0000;
      m_ram[k] = 16'h0000;
    end
    for (int k = 0; k < 16; k++) begin
      m_ds[k] = 16'h0000;
      m_rs[k] = 16'h0000;
    end
    m_T = 16'h0000; m_din = 16'h0000;
    m_pc = 0; m_dsp = 0; m_rsp = 0; m_reboot = 1'b1;

    // Directed table: reboot, literals/add, branches, call/return, memory, wrap.
    addv(16'h8005, 13'h000, 13'h0000, 1'b0, 16'h0000);
    addv(16'h8005, 13'h001, 13'h0005, 1'b0, 16'h0000);
    addv(16'h8003, 13'h002, 13'h0003, 1'b0, 16'h0000);
    addv(16'h6203, 13'h003, 13'h0008, 1'b0, 16'h0005);
    addv(16'h6E00, 13'h004, 13'h0010, 1'b0, 16'h0000);
    addv(16'h0010, 13'h010, 13'h0010, 1'b0, 16'h0000);
    addv(16'h8000, 13'h011, 13'h0000, 1'b0, 16'h0000);
    addv(16'h2020, 13'h020, 13'h0010, 1'b0, 16'h0010);
    addv(16'h8001, 13'h021, 13'h0001, 1'b0, 16'h0000);
    addv(16'h2020, 13'h022, 13'h0010, 1'b0, 16'h0010);
    addv(16'h6E00, 13'h023, 13'h0010, 1'b0, 16'h0000);
    addv(16'h0005, 13'h005, 13'h0010, 1'b0, 16'h0000);
    addv(16'h4040, 13'h040, 13'h0010, 1'b0, 16'h0000);
    addv(16'h6B00, 13'h041, 13'h000C, 1'b0, 16'h0000);
    addv(16'h700C, 13'h006, 13'h000C, 1'b0, 16'h0000);
    addv(16'h6E00, 13'h007, 13'h0010, 1'b0, 16'h0000);
    addv(16'h9234, 13'h008, 13'h1234, 1'b0, 16'h0000);
    addv(16'h8010, 13'h009, 13'h0010, 1'b0, 16'h0010);
    addv(16'h6023, 13'h00A, 13'h0010, 1'b1, 16'h1234);
    addv(16'h8010, 13'h00B, 13'h0010, 1'b0, 16'h0010);
    addv(16'h6D00, 13'h00C, 13'h1234, 1'b0, 16'h0010);
    addv(16'h6002, 13'h00D, 13'h1234, 1'b0, 16'h0010);
    addv(16'h6003, 13'h00E, 13'h1234, 1'b0, 16'h0000);
    for (int k = 1; k <= 17; k++) begin
      addv(16'h8000 | 16'(k), 13'(14 + k), 13'(k), 1'b0,
           (k == 1) ? 16'h0000 : (k == 2) ? 16'h1234 : 16'(k - 2));
    end
    addv(16'h6E00, 13'h020, 13'h0010, 1'b0, 16'h0010);

    reset = 1'b0;
    insn  = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("reset%0d code_addr", k), 32'(code_addr), 32'h0);
      chk($sformatf("reset%0d mem_wr", k), 32'(mem_wr), 32'h0);
    end
    reset = 1'b1;

    foreach (vecs[v]) begin
      insn = vecs[v].insn;
      #1;
      chk($sformatf("vec%0d code_addr", v), 32'(code_addr), 32'(vecs[v].code));
      chk($sformatf("vec%0d mem_addr", v), 32'(mem_addr), 32'(vecs[v].maddr));
      chk($sformatf("vec%0d mem_wr", v), 32'(mem_wr), 32'(vecs[v].wr));
      chk($sformatf("vec%0d dout", v), 32'(dout), 32'(vecs[v].dout));
      model_step(vecs[v].insn, e_code, e_maddr, e_wr, e_dout);
      @(negedge clk);
    end

    for (int s = 0; s < 1500; s++) begin
      ri = 16'($urandom);
      insn = ri;
      #1;
      model_step(ri, e_code, e_maddr, e_wr, e_dout);
      chk($sformatf("rnd%0d code_addr insn=%h", s, ri), 32'(code_addr), 32'(e_code));
      chk($sformatf("rnd%0d mem_addr insn=%h", s, ri), 32'(mem_addr), 32'(e_maddr));
      chk($sformatf("rnd%0d mem_wr insn=%h", s, ri), 32'(mem_wr), 32'(e_wr));
      chk($sformatf("rnd%0d dout insn=%h", s, ri), 32'(dout), 32'(e_dout));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
